// File: rtl/led_display_scheduler.sv
// Round-robin time-sharing of the 16-bit LED bank between NUM_SRC requesters.
// Each grant holds its captured pattern for HOLD_CYCLES; a heartbeat fills idle time.
//
// state | meaning
// IDLE  | no display owner; LEDs show the heartbeat bit
// SHOW  | a granted pattern is held on the LEDs until hold_cnt reaches 0
module led_display_scheduler #(
  parameter int NUM_SRC     = 3,
  parameter int HOLD_CYCLES = 100_000_000,
  parameter int HB_CYCLES   = 50_000_000,
  localparam int SRC_W      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                   sys_clk,
  input  logic                   rst_n,
  input  logic [NUM_SRC-1:0]     req,
  input  logic [16*NUM_SRC-1:0]  pattern,
  output logic [NUM_SRC-1:0]     ack,
  output logic                   busy,
  output logic [SRC_W-1:0]       active_src,
  output logic [15:0]            led
);

  localparam int HOLD_W = $clog2(HOLD_CYCLES);
  localparam int HB_W   = (HB_CYCLES > 1) ? $clog2(HB_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [HB_W-1:0]   HB_LAST   = HB_W'(HB_CYCLES - 1);
  localparam logic [SRC_W-1:0]  SRC_LAST  = SRC_W'(NUM_SRC - 1);

  typedef enum logic {IDLE, SHOW} state_t;

  state_t            state, next_state;
  logic [HOLD_W-1:0] hold_cnt, hold_nxt;
  logic [HB_W-1:0]   hb_cnt;
  logic              hb_bit;
  logic [SRC_W-1:0]  rr_last, rr_nxt;
  logic [15:0]       led_nxt;
  logic [NUM_SRC-1:0] ack_nxt;
  logic [SRC_W-1:0]  active_nxt;

  logic [15:0]       pat_slot [NUM_SRC];
  logic              arb;
  logic              grant_valid;
  logic [SRC_W-1:0]  grant_idx;
  logic [SRC_W-1:0]  cand_idx;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_slot
    assign pat_slot[i] = pattern[16*i +: 16];
  end

  // Search starts one past the last winner so every requester gets a turn.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand_idx    = '0;
    for (int i = 1; i <= NUM_SRC; i++) begin
      cand_idx = SRC_W'((int'(rr_last) + i) % NUM_SRC);
      if (!grant_valid && req[cand_idx]) begin
        grant_valid = 1'b1;
        grant_idx   = cand_idx;
      end
    end
  end

  assign arb  = grant_valid && ((state == IDLE) || (hold_cnt == '0));
  assign busy = (state == SHOW);

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (arb) next_state = SHOW;
      SHOW: if (hold_cnt == '0 && !arb) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Leaving SHOW without a new grant loads the heartbeat on the same edge,
  // so a display lasts exactly HOLD_CYCLES.
  always_comb begin
    led_nxt    = led;
    ack_nxt    = '0;
    active_nxt = active_src;
    rr_nxt     = rr_last;
    hold_nxt   = hold_cnt;
    if (arb) begin
      led_nxt             = pat_slot[grant_idx];
      ack_nxt[grant_idx]  = 1'b1;
      active_nxt          = grant_idx;
      rr_nxt              = grant_idx;
      hold_nxt            = HOLD_LAST;
    end else if (state == SHOW && hold_cnt != '0) begin
      hold_nxt = hold_cnt - 1'b1;
    end else begin
      led_nxt = {15'b0, hb_bit};
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      led        <= '0;
      ack        <= '0;
      active_src <= '0;
      rr_last    <= SRC_LAST;
      hold_cnt   <= '0;
    end else begin
      led        <= led_nxt;
      ack        <= ack_nxt;
      active_src <= active_nxt;
      rr_last    <= rr_nxt;
      hold_cnt   <= hold_nxt;
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      hb_cnt <= '0;
      hb_bit <= 1'b0;
    end else if (hb_cnt == HB_LAST) begin
      hb_cnt <= '0;
      hb_bit <= ~hb_bit;
    end else begin
      hb_cnt <= hb_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_led_display_scheduler.sv
// Bench for led_display_scheduler: directed scenarios plus random requests,
// every cycle compared against a remaining-time / rotating-priority model.
module tb_led_display_scheduler;

  localparam int N  = 3;
  localparam int H  = 8;
  localparam int HB = 4;

  logic              sys_clk = 1'b0;
  logic              rst_n   = 1'b1;
  logic [N-1:0]      req     = '0;
  logic [16*N-1:0]   pattern = '0;
  logic [N-1:0]      ack;
  logic              busy;
  logic [1:0]        active_src;
  logic [15:0]       led;

  led_display_scheduler #(.NUM_SRC(N), .HOLD_CYCLES(H), .HB_CYCLES(HB)) dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .req(req), .pattern(pattern),
    .ack(ack), .busy(busy), .active_src(active_src), .led(led)
  );

  always #5 sys_clk = ~sys_clk;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model
  int          m_left, m_rr, m_edges, m_src;
  logic [15:0] m_led;
  logic [N-1:0] m_ack;
  logic        m_busy;
  int          grants[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_left = 0; m_rr = N - 1; m_edges = 0; m_src = 0;
    m_led = '0; m_ack = '0; m_busy = 1'b0;
  endtask

  task automatic model_edge();
    int g;
    g = -1;
    m_edges++;
    m_ack = '0;
    if (m_left > 1) begin
      m_left--;
    end else begin
      for (int i = 1; i <= N; i++)
        if (g < 0 && req[(m_rr + i) % N]) g = (m_rr + i) % N;
      if (g >= 0) begin
        m_led = pattern[16*g +: 16];
        m_ack[g] = 1'b1;
        m_src = g; m_rr = g; m_left = H; m_busy = 1'b1;
        grants.push_back(g);
      end else begin
        m_left = 0; m_busy = 1'b0;
        m_led = 16'(((m_edges - 1) / HB) % 2);
      end
    end
  endtask

  task automatic step(input string tag);
    @(posedge sys_clk);
    model_edge();
    #1;
    chk({tag, " led"}, 32'(led), 32'(m_led));
    chk({tag, " ack"}, 32'(ack), 32'(m_ack));
    chk({tag, " busy"}, 32'(busy), 32'(m_busy));
    chk({tag, " active_src"}, 32'(active_src), 32'(m_src));
  endtask

  // Asserted mid-cycle; outputs must clear without waiting for a clock edge.
  task automatic do_reset(input string tag);
    #3;
    rst_n = 1'b0;
    #1;
    chk({tag, " rst led"}, 32'(led), 32'h0);
    chk({tag, " rst ack"}, 32'(ack), 32'h0);
    chk({tag, " rst busy"}, 32'(busy), 32'h0);
    chk({tag, " rst active_src"}, 32'(active_src), 32'h0);
    model_reset();
    grants.delete();
    repeat (2) @(negedge sys_clk);
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();

    // T1: reset and heartbeat
    do_reset("t1");
    for (int c = 0; c < 16; c++) step("t1 hb");

    // T2: single request
    pattern[16 +: 16] = 16'hA5A5;
    req = 3'b010;
    step("t2 grant");
    chk("t2 ack pulse", 32'(ack), 32'h2);
    req = 3'b000;
    for (int c = 0; c < 7; c++) begin
      step("t2 hold");
      chk("t2 led held", 32'(led), 32'hA5A5);
      chk("t2 busy held", 32'(busy), 32'h1);
    end
    step("t2 end");
    chk("t2 idle busy", 32'(busy), 32'h0);
    for (int c = 0; c < 6; c++) step("t2 hb");

    // T3: all request, strict rotation with no idle gap
    do_reset("t3");
    pattern = {16'h3333, 16'h2222, 16'h1111};
    req = 3'b111;
    for (int c = 0; c < 4 * H; c++) begin
      step("t3 run");
      chk("t3 no gap", 32'(busy), 32'h1);
    end
    chk("t3 grant count", 32'(grants.size()), 32'd4);
    if (grants.size() == 4) begin
      chk("t3 g0", 32'(grants[0]), 32'd0);
      chk("t3 g1", 32'(grants[1]), 32'd1);
      chk("t3 g2", 32'(grants[2]), 32'd2);
      chk("t3 g3", 32'(grants[3]), 32'd0);
    end
    req = '0;

    // T4: fairness against a hogging source
    do_reset("t4");
    pattern = {16'h0F00, 16'h00F0, 16'h000F};
    req = 3'b001;
    for (int c = 0; c < 4; c++) step("t4 src0");
    req = 3'b101;
    for (int c = 0; c < 20 && grants.size() < 2; c++) step("t4 wait");
    chk("t4 second grant seen", 32'(grants.size() >= 2), 32'h1);
    if (grants.size() >= 2) chk("t4 next grant", 32'(grants[1]), 32'd2);
    chk("t4 led src2", 32'(led), 32'h0F00);
    req = '0;

    // T5: reset mid-SHOW restores source-0 priority
    do_reset("t5a");
    req = 3'b001;
    for (int c = 0; c < 5; c++) step("t5 show");
    req = '0;
    do_reset("t5b");
    req = 3'b111;
    step("t5 after");
    chk("t5 ack src0", 32'(ack), 32'h1);
    req = '0;

    // T6: pattern change during SHOW is ignored
    do_reset("t6");
    pattern[16 +: 16] = 16'h1234;
    req = 3'b010;
    step("t6 grant");
    pattern[16 +: 16] = 16'hFFFF;
    req = '0;
    for (int c = 0; c < 7; c++) begin
      step("t6 hold");
      chk("t6 led frozen", 32'(led), 32'h1234);
    end
    step("t6 end");

    // randomized traffic, including occasional protocol violations and resets
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < N; i++) begin
        if (m_ack[i] && $urandom_range(1, 0) == 1) req[i] = 1'b0;
        else if (!req[i] && $urandom_range(3, 0) == 0) begin
          req[i] = 1'b1;
          pattern[16*i +: 16] = 16'($urandom);
        end else if (req[i] && !m_ack[i] && $urandom_range(63, 0) == 0) req[i] = 1'b0;
        if ($urandom_range(7, 0) == 0) pattern[16*i +: 16] = 16'($urandom);
      end
      if ($urandom_range(299, 0) == 0) do_reset("rnd");
      step("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
